tournament_choice_table: RTL and testbench
==========================================

# tournament_choice_table

Chooser stage of the tournament branch predictor. It holds a table of 2-bit saturating counters indexed by PC XOR global history, and delivers `choice_prediction_o` to the global/local selection mux one cycle after each lookup. It trains each counter when a branch resolves, according to which component predictor was correct. It also owns the global history register (GHR) shared by the chooser index.

## Interface

- `INDEX_BITS`, default 6: log2 of table entries (64 counters).
- `HIST_BITS`, default 6: GHR width; legal range 1 ≤ `HIST_BITS` ≤ `INDEX_BITS`.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `lookup_v_i`  in  1: lookup request this cycle.
- `lookup_pc_i`  in  32: branch PC.
- `choice_v_o`  out  1: one-cycle pulse; choice outputs are valid.
- `choice_prediction_o`  out  2: counter value. ≥ 2'b10 selects global; < 2'b10 selects local.
- `choice_idx_o`  out  `INDEX_BITS`: index used. The pipeline carries it back as `update_idx_i`.
- `update_v_i`  in  1: branch resolution this cycle.
- `update_idx_i`  in  `INDEX_BITS`: counter to train.
- `update_taken_i`  in  1: actual outcome.
- `update_global_pred_i`  in  1: what the global predictor predicted.
- `update_local_pred_i`  in  1: what the local predictor predicted.
- `ghr_o`  out  `HIST_BITS`: current GHR.

## Operation

- **Index**: idx = `lookup_pc_i[INDEX_BITS+1:2]` XOR zero-extend(GHR).
  - The GHR value used is the one held at the start of the cycle. A same-cycle GHR shift is not visible to the lookup.
- **Counter training**, on `update_v_i`, applied to entry `update_idx_i`:
  - g_ok = (`update_global_pred_i` == `update_taken_i`); l_ok = (`update_local_pred_i` == `update_taken_i`).
  - g_ok & !l_ok: increment, saturating at 2'b11.
  - !g_ok & l_ok: decrement, saturating at 2'b00.
  - Otherwise: hold.
- **GHR**, on `update_v_i`: GHR ← {GHR[HIST_BITS-2:0], `update_taken_i`}. When `HIST_BITS`=1, GHR ← `update_taken_i`.
- **Bypass**: if `lookup_v_i` and `update_v_i` are both asserted in the same cycle with the computed lookup idx == `update_idx_i`, the lookup returns the post-update counter value.
- **Hold behaviour**: `choice_prediction_o` and `choice_idx_o` hold their last values while no lookup is in progress. `choice_v_o` is 0 in those cycles.
- **Storage**: the table is flop-based. There are no read/write port conflicts other than the bypass case above.

## Timing

- **Lookup latency**: 1 cycle. A lookup sampled at edge N drives `choice_v_o`=1 and the outputs after edge N, i.e. valid in cycle N+1.
- **Update latency**: an update sampled at edge N is visible to any lookup sampled at edge N+1 and later. A lookup at edge N sees it through the bypass.
- **Throughput**: back-to-back lookups and updates are accepted every cycle. There is no stall or backpressure.
- **Reset values**:
  - All counters = 2'b01 (weakly local).
  - GHR = 0.
  - `choice_v_o` = 0, `choice_prediction_o` = 2'b01, `choice_idx_o` = 0, `ghr_o` = 0.
- **Reset precedence**: `reset` overrides any same-cycle lookup or update. Neither takes effect.
- **Reset mid-operation**: a lookup issued in the cycle before reset still produces its `choice_v_o` pulse unless reset is asserted at that output edge. If reset is asserted at that edge, outputs take their reset values.

## Test plan

All scenarios use `INDEX_BITS`=6 and `HIST_BITS`=6.

1. **Reset then lookup**: release reset, then lookup pc=0x40 → next cycle `choice_v_o`=1, `choice_prediction_o`=2'b01, `choice_idx_o`=0x10; the following cycle `choice_v_o`=0 with the outputs held.
2. **Saturating increment**:
   - Stimulus: three updates to idx 0x10 with taken=1, global=1, local=0.
   - Counter goes 01→10→11→11; `ghr_o`=0x07.
   - Then lookup pc=0x5C → idx 0x10, choice=2'b11.
3. **Saturating decrement**:
   - Stimulus: two updates to idx 0x05 with taken=0, global=1, local=0.
   - Counter goes 01→00→00; GHR shifts in zeros.
   - Lookup that hits idx 0x05 → choice=2'b00.
4. **Hold cases**:
   - Stimulus: updates to idx 0x10 (counter at 2'b11) with both predictors correct, then both wrong.
   - Counter stays 2'b11; GHR still shifts on each update.
5. **Same-cycle bypass**:
   - Stimulus: with counter 0x10=2'b01 and GHR=0, assert lookup pc=0x40 together with update idx 0x10, taken=1, global=1, local=0.
   - Next cycle: choice=2'b10, idx=0x10.
   - Following cycle: `ghr_o`=0x01.
6. **Reset mid-operation**:
   - Stimulus: assert reset in the same cycle as an update and a lookup, after counters have been trained.
   - Next cycle: `choice_v_o`=0 and all outputs at reset values.
   - A subsequent lookup of any trained index returns 2'b01.

Source files
------------

// File: rtl/tournament_choice_table.sv
// -----------------------------------------------------------------------------
// tournament_choice_table
//
// Chooser stage of a tournament branch predictor. A flop-based table of 2-bit
// saturating counters, indexed by PC[INDEX_BITS+1:2] XOR the global history
// register (GHR), tells the selection mux which component predictor to trust:
// a counter >= 2'b10 selects the global predictor, < 2'b10 selects the local one.
//
// Ports:
//   clk                  - single clock, rising edge
//   reset                - synchronous, active-high
//   lookup_v_i           - lookup request this cycle
//   lookup_pc_i          - branch PC for the lookup
//   choice_v_o           - one-cycle pulse, choice outputs valid
//   choice_prediction_o  - counter value read by the lookup (held between lookups)
//   choice_idx_o         - table index used by the lookup (held between lookups)
//   update_v_i           - branch resolution this cycle
//   update_idx_i         - counter to train (the choice_idx_o carried down the pipe)
//   update_taken_i       - actual branch outcome
//   update_global_pred_i - what the global predictor predicted
//   update_local_pred_i  - what the local predictor predicted
//   ghr_o                - current global history
// -----------------------------------------------------------------------------
module tournament_choice_table #(
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lookup_v_i,
  input  logic [31:0]           lookup_pc_i,
  output logic                  choice_v_o,
  output logic [1:0]            choice_prediction_o,
  output logic [INDEX_BITS-1:0] choice_idx_o,
  input  logic                  update_v_i,
  input  logic [INDEX_BITS-1:0] update_idx_i,
  input  logic                  update_taken_i,
  input  logic                  update_global_pred_i,
  input  logic                  update_local_pred_i,
  output logic [HIST_BITS-1:0]  ghr_o
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            table_reg [ENTRIES];
  logic [HIST_BITS-1:0]  ghr_reg;
  logic [HIST_BITS-1:0]  ghr_next;

  logic [INDEX_BITS-1:0] ghr_ext;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [1:0]            lookup_cnt;

  logic                  g_ok;
  logic                  l_ok;
  logic [1:0]            upd_old;
  logic [1:0]            upd_new;

  // PC bits outside the index field do not participate in the hash.
  logic                  unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[31:INDEX_BITS+2], lookup_pc_i[1:0]};

  // ---------------------------------------------------------------------------
  // Counter training: move toward whichever predictor was uniquely right.
  // ---------------------------------------------------------------------------
  always_comb begin
    upd_old = table_reg[update_idx_i];
    g_ok    = (update_global_pred_i == update_taken_i);
    l_ok    = (update_local_pred_i  == update_taken_i);
    upd_new = upd_old;
    if (g_ok && !l_ok && (upd_old != 2'b11)) begin
      upd_new = upd_old + 2'd1;
    end else if (!g_ok && l_ok && (upd_old != 2'b00)) begin
      upd_new = upd_old - 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // GHR shift. A 1-bit history simply holds the last outcome.
  // ---------------------------------------------------------------------------
  generate
    if (HIST_BITS == 1) begin : g_ghr_one
      assign ghr_next = update_taken_i;
    end else begin : g_ghr_wide
      assign ghr_next = {ghr_reg[HIST_BITS-2:0], update_taken_i};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Lookup index uses the GHR held at the start of the cycle, so a same-cycle
  // history shift never affects it.
  // ---------------------------------------------------------------------------
  always_comb begin
    ghr_ext                  = '0;
    ghr_ext[HIST_BITS-1:0]   = ghr_reg;
    lookup_idx               = lookup_pc_i[INDEX_BITS+1:2] ^ ghr_ext;
  end

  // Bypass: a lookup colliding with a same-cycle update sees the trained value.
  always_comb begin
    if (update_v_i && (update_idx_i == lookup_idx)) begin
      lookup_cnt = upd_new;
    end else begin
      lookup_cnt = table_reg[lookup_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Table and GHR state. Every counter resets to weakly-local.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_reg[i] <= 2'b01;
      end
      ghr_reg <= '0;
    end else if (update_v_i) begin
      table_reg[update_idx_i] <= upd_new;
      ghr_reg                 <= ghr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered lookup outputs; prediction and index hold between lookups.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      choice_v_o          <= 1'b0;
      choice_prediction_o <= 2'b01;
      choice_idx_o        <= '0;
    end else begin
      choice_v_o <= lookup_v_i;
      if (lookup_v_i) begin
        choice_prediction_o <= lookup_cnt;
        choice_idx_o        <= lookup_idx;
      end
    end
  end

  assign ghr_o = ghr_reg;

endmodule

// File: tb/tb_tournament_choice_table.sv
// -----------------------------------------------------------------------------
// tb_tournament_choice_table
//
// Directed bench for tournament_choice_table (INDEX_BITS=6, HIST_BITS=6).
// Inputs change 1 ns after the rising edge; outputs are sampled at that same
// point, i.e. away from the active edge. Each scenario task carries its own
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_tournament_choice_table;

  localparam int IB = 6;
  localparam int HB = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          lookup_v_i;
  logic [31:0]   lookup_pc_i;
  logic          choice_v_o;
  logic [1:0]    choice_prediction_o;
  logic [IB-1:0] choice_idx_o;
  logic          update_v_i;
  logic [IB-1:0] update_idx_i;
  logic          update_taken_i;
  logic          update_global_pred_i;
  logic          update_local_pred_i;
  logic [HB-1:0] ghr_o;

  int tests_run = 0;
  int tests_failed = 0;

  tournament_choice_table #(
    .INDEX_BITS(IB),
    .HIST_BITS (HB)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .lookup_v_i          (lookup_v_i),
    .lookup_pc_i         (lookup_pc_i),
    .choice_v_o          (choice_v_o),
    .choice_prediction_o (choice_prediction_o),
    .choice_idx_o        (choice_idx_o),
    .update_v_i          (update_v_i),
    .update_idx_i        (update_idx_i),
    .update_taken_i      (update_taken_i),
    .update_global_pred_i(update_global_pred_i),
    .update_local_pred_i (update_local_pred_i),
    .ghr_o               (ghr_o)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lookup_v_i           = 1'b0;
    lookup_pc_i          = 32'h0;
    update_v_i           = 1'b0;
    update_idx_i         = '0;
    update_taken_i       = 1'b0;
    update_global_pred_i = 1'b0;
    update_local_pred_i  = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Single-cycle lookup; outputs are valid when this returns.
  task automatic do_lookup(input logic [31:0] pc);
    lookup_v_i  = 1'b1;
    lookup_pc_i = pc;
    tick();
    lookup_v_i  = 1'b0;
  endtask

  task automatic do_update(input logic [IB-1:0] idx, input logic t,
                           input logic g, input logic l);
    update_v_i           = 1'b1;
    update_idx_i         = idx;
    update_taken_i       = t;
    update_global_pred_i = g;
    update_local_pred_i  = l;
    tick();
    update_v_i           = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({choice_v_o, choice_prediction_o, choice_idx_o, ghr_o} !== {1'b1 ^ 1'b1, 2'b01, 6'h00, 6'h00}) begin
      tests_failed++;
      $display("FAIL reset_state: v=%0b pred=%b idx=%h ghr=%h, required v=0 pred=01 idx=00 ghr=00",
               choice_v_o, choice_prediction_o, choice_idx_o, ghr_o);
    end
    $display("[TB] reset_state v=%0b pred=%b idx=%h ghr=%h", choice_v_o, choice_prediction_o, choice_idx_o, ghr_o);
  endtask

  task automatic test_lookup_after_reset();
    do_lookup(32'h40);
    tests_run++;
    if ({choice_v_o, choice_prediction_o, choice_idx_o} !== {1'b1, 2'b01, 6'h10}) begin
      tests_failed++;
      $display("FAIL first_lookup: v=%0b pred=%b idx=%h, required v=1 pred=01 idx=10",
               choice_v_o, choice_prediction_o, choice_idx_o);
    end
    $display("[TB] lookup pc=40 v=%0b pred=%b idx=%h", choice_v_o, choice_prediction_o, choice_idx_o);
    tick();
    tests_run++;
    if ({choice_v_o, choice_prediction_o, choice_idx_o} !== {1'b0, 2'b01, 6'h10}) begin
      tests_failed++;
      $display("FAIL first_hold: v=%0b pred=%b idx=%h, required v=0 pred=01 idx=10",
               choice_v_o, choice_prediction_o, choice_idx_o);
    end
    $display("[TB] idle v=%0b pred=%b idx=%h", choice_v_o, choice_prediction_o, choice_idx_o);
  endtask

  // Counter 0x10: 01 -> 10 -> 11 -> 11. After each update the GHR is 1, 3, 7,
  // so PCs 0x44, 0x4C, 0x5C all hash back to index 0x10.
  task automatic test_saturating_increment();
    logic [31:0] pcs [3];
    logic [1:0]  exp_cnt [3];
    pcs[0] = 32'h44; pcs[1] = 32'h4C; pcs[2] = 32'h5C;
    exp_cnt[0] = 2'b10; exp_cnt[1] = 2'b11; exp_cnt[2] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      do_update(6'h10, 1'b1, 1'b1, 1'b0);
      do_lookup(pcs[k]);
      tests_run++;
      if ({choice_v_o, choice_prediction_o, choice_idx_o} !== {1'b1, exp_cnt[k], 6'h10}) begin
        tests_failed++;
        $display("FAIL inc_step%0d: v=%0b pred=%b idx=%h, required v=1 pred=%b idx=10",
                 k, choice_v_o, choice_prediction_o, choice_idx_o, exp_cnt[k]);
      end
      $display("[TB] inc update %0d lookup pc=%h pred=%b idx=%h ghr=%h",
               k, pcs[k], choice_prediction_o, choice_idx_o, ghr_o);
    end
    tests_run++;
    if (ghr_o !== 6'h07) begin
      tests_failed++;
      $display("FAIL inc_ghr: ghr=%h, required 07", ghr_o);
    end
    tick();
    tests_run++;
    if ({choice_v_o, choice_prediction_o, choice_idx_o} !== {1'b0, 2'b11, 6'h10}) begin
      tests_failed++;
      $display("FAIL inc_hold: v=%0b pred=%b idx=%h, required v=0 pred=11 idx=10",
               choice_v_o, choice_prediction_o, choice_idx_o);
    end
    $display("[TB] idle hold v=%0b pred=%b idx=%h", choice_v_o, choice_prediction_o, choice_idx_o);
  endtask

  // Counter 0x05: 01 -> 00 -> 00; GHR 07 -> 0E -> 1C. PC 0x64 -> 0x19^0x1C = 0x05.
  task automatic test_saturating_decrement();
    do_update(6'h05, 1'b0, 1'b1, 1'b0);
    do_update(6'h05, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (ghr_o !== 6'h1C) begin
      tests_failed++;
      $display("FAIL dec_ghr: ghr=%h, required 1c", ghr_o);
    end
    do_lookup(32'h64);
    tests_run++;
    if ({choice_v_o, choice_prediction_o, choice_idx_o} !== {1'b1, 2'b00, 6'h05}) begin
      tests_failed++;
      $display("FAIL dec_lookup: v=%0b pred=%b idx=%h, required v=1 pred=00 idx=05",
               choice_v_o, choice_prediction_o, choice_idx_o);
    end
    $display("[TB] dec lookup pc=64 pred=%b idx=%h ghr=%h", choice_prediction_o, choice_idx_o, ghr_o);
  endtask

  // Both right then both wrong on 0x10 (at 11): counter holds, GHR 1C -> 39 -> 32.
  // PC 0x88 -> 0x22^0x32 = 0x10.
  task automatic test_hold_cases();
    do_update(6'h10, 1'b1, 1'b1, 1'b1);
    tests_run++;
    if (ghr_o !== 6'h39) begin
      tests_failed++;
      $display("FAIL hold_ghr1: ghr=%h, required 39", ghr_o);
    end
    do_update(6'h10, 1'b0, 1'b1, 1'b1);
    tests_run++;
    if (ghr_o !== 6'h32) begin
      tests_failed++;
      $display("FAIL hold_ghr2: ghr=%h, required 32", ghr_o);
    end
    do_lookup(32'h88);
    tests_run++;
    if ({choice_v_o, choice_prediction_o, choice_idx_o} !== {1'b1, 2'b11, 6'h10}) begin
      tests_failed++;
      $display("FAIL hold_lookup: v=%0b pred=%b idx=%h, required v=1 pred=11 idx=10",
               choice_v_o, choice_prediction_o, choice_idx_o);
    end
    $display("[TB] hold lookup pc=88 pred=%b idx=%h ghr=%h", choice_prediction_o, choice_idx_o, ghr_o);
  endtask

  // Fresh table, GHR=0: lookup 0x40 collides with an increment of 0x10.
  task automatic test_bypass();
    apply_reset();
    lookup_v_i           = 1'b1;
    lookup_pc_i          = 32'h40;
    update_v_i           = 1'b1;
    update_idx_i         = 6'h10;
    update_taken_i       = 1'b1;
    update_global_pred_i = 1'b1;
    update_local_pred_i  = 1'b0;
    tick();
    idle_inputs();
    tests_run++;
    if ({choice_v_o, choice_prediction_o, choice_idx_o} !== {1'b1, 2'b10, 6'h10}) begin
      tests_failed++;
      $display("FAIL bypass_lookup: v=%0b pred=%b idx=%h, required v=1 pred=10 idx=10",
               choice_v_o, choice_prediction_o, choice_idx_o);
    end
    $display("[TB] bypass lookup pc=40 pred=%b idx=%h", choice_prediction_o, choice_idx_o);
    tick();
    tests_run++;
    if ({choice_v_o, ghr_o} !== {1'b0, 6'h01}) begin
      tests_failed++;
      $display("FAIL bypass_ghr: v=%0b ghr=%h, required v=0 ghr=01", choice_v_o, ghr_o);
    end
    // Stored value matches the bypassed one; GHR=1 so PC 0x44 -> 0x10.
    do_lookup(32'h44);
    tests_run++;
    if ({choice_prediction_o, choice_idx_o} !== {2'b10, 6'h10}) begin
      tests_failed++;
      $display("FAIL bypass_stored: pred=%b idx=%h, required pred=10 idx=10",
               choice_prediction_o, choice_idx_o);
    end
    $display("[TB] post-bypass lookup pc=44 pred=%b idx=%h", choice_prediction_o, choice_idx_o);
  endtask

  // Same-cycle update to a different index must not leak into the lookup.
  // GHR=1: PC 0x44 -> 0x10 (counter 10); update decrements 0x20 (01 -> 00).
  task automatic test_back_to_back();
    lookup_v_i           = 1'b1;
    lookup_pc_i          = 32'h44;
    update_v_i           = 1'b1;
    update_idx_i         = 6'h20;
    update_taken_i       = 1'b0;
    update_global_pred_i = 1'b1;
    update_local_pred_i  = 1'b0;
    tick();
    // GHR now 2: PC 0x88 -> 0x22^0x02 = 0x20, counter 00; keep lookup asserted.
    lookup_pc_i = 32'h88;
    update_v_i  = 1'b0;
    tests_run++;
    if ({choice_v_o, choice_prediction_o, choice_idx_o} !== {1'b1, 2'b10, 6'h10}) begin
      tests_failed++;
      $display("FAIL b2b_first: v=%0b pred=%b idx=%h, required v=1 pred=10 idx=10",
               choice_v_o, choice_prediction_o, choice_idx_o);
    end
    $display("[TB] b2b lookup pc=44 pred=%b idx=%h", choice_prediction_o, choice_idx_o);
    tick();
    idle_inputs();
    tests_run++;
    if ({choice_v_o, choice_prediction_o, choice_idx_o} !== {1'b1, 2'b00, 6'h20}) begin
      tests_failed++;
      $display("FAIL b2b_second: v=%0b pred=%b idx=%h, required v=1 pred=00 idx=20",
               choice_v_o, choice_prediction_o, choice_idx_o);
    end
    $display("[TB] b2b lookup pc=88 pred=%b idx=%h ghr=%h", choice_prediction_o, choice_idx_o, ghr_o);
  endtask

  // Train 0x10 to 11 (GHR 02 -> 05 -> 0B), then reset alongside a lookup and update.
  task automatic test_reset_mid_operation();
    do_update(6'h10, 1'b1, 1'b1, 1'b0);
    do_update(6'h10, 1'b1, 1'b1, 1'b0);
    // Lookup pulse issued just before reset: PC 0x6C -> 0x1B^0x0B = 0x10, counter 11.
    lookup_v_i  = 1'b1;
    lookup_pc_i = 32'h6C;
    tick();
    tests_run++;
    if ({choice_v_o, choice_prediction_o, choice_idx_o} !== {1'b1, 2'b11, 6'h10}) begin
      tests_failed++;
      $display("FAIL pre_reset_lookup: v=%0b pred=%b idx=%h, required v=1 pred=11 idx=10",
               choice_v_o, choice_prediction_o, choice_idx_o);
    end
    reset                = 1'b1;
    update_v_i           = 1'b1;
    update_idx_i         = 6'h10;
    update_taken_i       = 1'b1;
    update_global_pred_i = 1'b1;
    update_local_pred_i  = 1'b0;
    tick();
    reset = 1'b0;
    idle_inputs();
    tests_run++;
    if ({choice_v_o, choice_prediction_o, choice_idx_o, ghr_o} !== {1'b0, 2'b01, 6'h00, 6'h00}) begin
      tests_failed++;
      $display("FAIL mid_reset_state: v=%0b pred=%b idx=%h ghr=%h, required v=0 pred=01 idx=00 ghr=00",
               choice_v_o, choice_prediction_o, choice_idx_o, ghr_o);
    end
    $display("[TB] mid reset v=%0b pred=%b idx=%h ghr=%h", choice_v_o, choice_prediction_o, choice_idx_o, ghr_o);
    do_lookup(32'h40);
    tests_run++;
    if ({choice_v_o, choice_prediction_o, choice_idx_o} !== {1'b1, 2'b01, 6'h10}) begin
      tests_failed++;
      $display("FAIL post_reset_lookup10: v=%0b pred=%b idx=%h, required v=1 pred=01 idx=10",
               choice_v_o, choice_prediction_o, choice_idx_o);
    end
    do_lookup(32'h80);
    tests_run++;
    if ({choice_v_o, choice_prediction_o, choice_idx_o} !== {1'b1, 2'b01, 6'h20}) begin
      tests_failed++;
      $display("FAIL post_reset_lookup20: v=%0b pred=%b idx=%h, required v=1 pred=01 idx=20",
               choice_v_o, choice_prediction_o, choice_idx_o);
    end
    $display("[TB] post-reset lookup pc=80 pred=%b idx=%h", choice_prediction_o, choice_idx_o);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_lookup_after_reset();
    test_saturating_increment();
    test_saturating_decrement();
    test_hold_cases();
    test_bypass();
    test_back_to_back();
    test_reset_mid_operation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
